// File: rtl/cache_fill_ctrl_pkg.sv
// rtl/cache_fill_ctrl_pkg.sv - shared widths, state encoding and line-offset helpers for cache_fill_ctrl
package cache_fill_ctrl_pkg;

    localparam int WORD_SIZE   = 16;
    localparam int LINE_SIZE   = 64;
    localparam int OFFSET_BITS = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_FILL    = 3'd2,
        ST_WR_MEM  = 3'd3,
        ST_WR_DONE = 3'd4
    } fill_state_t;

    // Word address of the first word of the line holding addr.
    function automatic logic [WORD_SIZE-1:0] line_base(input logic [WORD_SIZE-1:0] addr);
        return {addr[WORD_SIZE-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_stats.sv
// rtl/cache_stats.sv - read access / hit counter pair, built only when CACHE_STATS_EN is defined
`ifdef CACHE_STATS_EN
module cache_stats (
    input  logic        clk,
    input  logic        reset,
    input  logic        access_inc,
    input  logic        hit_inc,
    output logic [15:0] stat_access,
    output logic [15:0] stat_hit
);

    // Free-running counters that wrap naturally at 2^16.
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_access <= 16'd0;
            stat_hit    <= 16'd0;
        end else begin
            if (access_inc) begin
                stat_access <= stat_access + 16'd1;
            end
            if (hit_inc) begin
                stat_hit <= stat_hit + 16'd1;
            end
        end
    end

endmodule
`endif

// File: rtl/cache_fill_ctrl.sv
// rtl/cache_fill_ctrl.sv - read-miss line fill and write-through controller; CACHE_STATS_EN adds access/hit counters
module cache_fill_ctrl #(
    parameter int WORD_SIZE = cache_fill_ctrl_pkg::WORD_SIZE,
    parameter int LINE_SIZE = cache_fill_ctrl_pkg::LINE_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cpu_read,
    input  logic                 cpu_write,
    input  logic [WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic                 cpu_stall,
    input  logic                 cache_hit,
    output logic [WORD_SIZE-1:0] cache_addr,
    output logic [LINE_SIZE-1:0] cache_line,
    output logic                 cache_readC,
    output logic                 cache_writeC,
    output logic                 cache_writeCword,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
`ifdef CACHE_STATS_EN
    output logic [15:0]          stat_access,
    output logic [15:0]          stat_hit,
`endif
    input  logic [LINE_SIZE-1:0] mem_rdata,
    input  logic                 mem_ack
);

    import cache_fill_ctrl_pkg::*;

    fill_state_t          state;
    logic [WORD_SIZE-1:0] req_addr;
    logic                 hit_at_entry;

    // Controller FSM; every memory and cache strobe is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            req_addr         <= '0;
            hit_at_entry     <= 1'b0;
            mem_req          <= 1'b0;
            mem_we           <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            cache_line       <= '0;
            cache_writeC     <= 1'b0;
            cache_writeCword <= 1'b0;
        end else begin
            cache_writeC     <= 1'b0;
            cache_writeCword <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cpu_write) begin
                        // A store takes priority; a read presented alongside it is dropped.
                        req_addr     <= cpu_addr;
                        hit_at_entry <= cache_hit;
                        mem_req      <= 1'b1;
                        mem_we       <= 1'b1;
                        mem_addr     <= cpu_addr;
                        mem_wdata    <= cpu_wdata;
                        state        <= ST_WR_MEM;
                    end else if (cpu_read && !cache_hit) begin
                        req_addr <= line_base(cpu_addr);
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= line_base(cpu_addr);
                        state    <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: begin
                    if (mem_ack) begin
                        // The outgoing line register doubles as the fill buffer.
                        mem_req      <= 1'b0;
                        cache_line   <= mem_rdata;
                        cache_writeC <= 1'b1;
                        state        <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    state <= ST_IDLE;
                end
                ST_WR_MEM: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        if (hit_at_entry) begin
                            cache_writeC     <= 1'b1;
                            cache_writeCword <= 1'b1;
                            cache_line       <= {mem_wdata, {(LINE_SIZE-WORD_SIZE){1'b0}}};
                        end
                        state <= ST_WR_DONE;
                    end
                end
                ST_WR_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Lookup address, lookup enable and stall follow the live CPU request while idle.
    always_comb begin
        cache_addr  = req_addr;
        cache_readC = 1'b0;
        cpu_stall   = 1'b1;
        case (state)
            ST_IDLE: begin
                cache_addr  = cpu_addr;
                cache_readC = cpu_read;
                cpu_stall   = cpu_write | (cpu_read & ~cache_hit);
            end
            ST_WR_DONE: begin
                cpu_stall = 1'b0;
            end
            default: begin
                cpu_stall = 1'b1;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic replay;
    logic idle_read;
    logic access_inc;
    logic hit_inc;

    // Remembers that the next idle read is the replay after a fill so it is not counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            replay <= 1'b0;
        end else if (state == ST_IDLE) begin
            replay <= idle_read & ~cache_hit;
        end
    end

    // One access per read at hit or miss detection; replay hits count as neither.
    always_comb begin
        idle_read  = (state == ST_IDLE) & cpu_read & ~cpu_write;
        access_inc = idle_read & (~cache_hit | ~replay);
        hit_inc    = idle_read & cache_hit & ~replay;
    end

    cache_stats u_cache_stats (
        .clk         (clk),
        .reset       (reset),
        .access_inc  (access_inc),
        .hit_inc     (hit_inc),
        .stat_access (stat_access),
        .stat_hit    (stat_hit)
    );
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb/tb_cache_fill_ctrl.sv - randomized scoreboard bench for cache_fill_ctrl; counters checked when CACHE_STATS_EN is defined
module tb_cache_fill_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_stall;
    logic        cache_hit;
    logic [15:0] cache_addr;
    logic [63:0] cache_line;
    logic        cache_readC;
    logic        cache_writeC;
    logic        cache_writeCword;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ack;
`ifdef CACHE_STATS_EN
    logic [15:0] stat_access;
    logic [15:0] stat_hit;
`endif

    cache_fill_ctrl #(.WORD_SIZE(16), .LINE_SIZE(64)) dut (
        .clk              (clk),
        .reset            (reset),
        .cpu_read         (cpu_read),
        .cpu_write        (cpu_write),
        .cpu_addr         (cpu_addr),
        .cpu_wdata        (cpu_wdata),
        .cpu_stall        (cpu_stall),
        .cache_hit        (cache_hit),
        .cache_addr       (cache_addr),
        .cache_line       (cache_line),
        .cache_readC      (cache_readC),
        .cache_writeC     (cache_writeC),
        .cache_writeCword (cache_writeCword),
        .mem_req          (mem_req),
        .mem_we           (mem_we),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
`ifdef CACHE_STATS_EN
        .stat_access      (stat_access),
        .stat_hit         (stat_hit),
`endif
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack)
    );

    // Cache model: one residency bit per line for word addresses 0x00..0xFF.
    logic [63:0] resident = '0;
    assign cache_hit = (cache_addr[15:8] == 8'h00) && resident[cache_addr[7:2]];

    typedef struct { logic we; logic [15:0] addr; logic [15:0] data; } mem_exp_t;
    typedef struct { logic word; logic [15:0] addr; logic [63:0] line; } cw_exp_t;
    typedef struct { int stall; logic [15:0] acc; logic [15:0] hits; } acc_exp_t;

    mem_exp_t    exp_mem[$];
    cw_exp_t     exp_cw[$];
    acc_exp_t    exp_acc[$];
    int          lat_q[$];
    logic [63:0] rdata_q[$];

    int checks = 0;
    int errors = 0;
    logic [15:0] m_access = '0;
    logic [15:0] m_hit = '0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    // Monitor: compares memory requests, cache writes, stall lengths and counters against the queues.
    mem_exp_t    me;
    cw_exp_t     ce;
    acc_exp_t    ae;
    int          stall_cnt = 0;
    logic        mon_req_q = 1'b0;
    logic        stats_due = 1'b0;
    logic [15:0] due_acc = '0;
    logic [15:0] due_hit = '0;

    always @(negedge clk) begin
`ifdef CACHE_STATS_EN
        if (stats_due) begin
            check("stat_access", 64'(stat_access), 64'(due_acc));
            check("stat_hit", 64'(stat_hit), 64'(due_hit));
        end
`endif
        stats_due = 1'b0;
        if (mem_req === 1'b1 && !mon_req_q) begin
            if (exp_mem.size() == 0) begin
                check("mem_req_expected", 64'(exp_mem.size()), 64'd1);
            end else begin
                me = exp_mem.pop_front();
                check("mem_we", 64'(mem_we), 64'(me.we));
                check("mem_addr", 64'(mem_addr), 64'(me.addr));
                if (me.we) check("mem_wdata", 64'(mem_wdata), 64'(me.data));
            end
        end
        mon_req_q = (mem_req === 1'b1);
        if (cache_writeC === 1'b1) begin
            if (exp_cw.size() == 0) begin
                check("cache_write_expected", 64'(exp_cw.size()), 64'd1);
            end else begin
                ce = exp_cw.pop_front();
                check("cache_writeCword", 64'(cache_writeCword), 64'(ce.word));
                check("cache_addr_on_write", 64'(cache_addr), 64'(ce.addr));
                check("cache_line", cache_line, ce.line);
            end
            if (!cache_writeCword) resident[cache_addr[7:2]] = 1'b1;
        end
        if (cpu_read || cpu_write) begin
            if (cpu_stall) begin
                stall_cnt++;
            end else begin
                if (exp_acc.size() == 0) begin
                    check("retire_expected", 64'(exp_acc.size()), 64'd1);
                end else begin
                    ae = exp_acc.pop_front();
                    check("stall_cycles", 64'(stall_cnt), 64'(ae.stall));
                    due_acc   = ae.acc;
                    due_hit   = ae.hits;
                    stats_due = 1'b1;
                end
                stall_cnt = 0;
            end
        end else begin
            stall_cnt = 0;
        end
    end

    // Memory responder: acks each request after its queued latency, garbage on rdata otherwise.
    int          rsp_k;
    logic [63:0] rsp_d;
    logic        rsp_req_q;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        rsp_req_q = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_rdata = {$urandom, $urandom};
            if (mem_req === 1'b1 && !rsp_req_q) begin
                rsp_k = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                rsp_d = (rdata_q.size() != 0) ? rdata_q.pop_front() : 64'h0;
                repeat (rsp_k) begin
                    @(posedge clk); #1;
                    mem_rdata = {$urandom, $urandom};
                end
                mem_ack   = 1'b1;
                mem_rdata = rsp_d;
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = {$urandom, $urandom};
            end
            rsp_req_q = (mem_req === 1'b1);
        end
    end

    task automatic check_idle(input string tag);
        check({tag, "_mem_req"}, 64'(mem_req), 64'd0);
        check({tag, "_mem_we"}, 64'(mem_we), 64'd0);
        check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
        check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
        check({tag, "_cache_line"}, cache_line, 64'd0);
        check({tag, "_cache_writeC"}, 64'(cache_writeC), 64'd0);
        check({tag, "_cache_writeCword"}, 64'(cache_writeCword), 64'd0);
        check({tag, "_cpu_stall"}, 64'(cpu_stall), 64'd0);
`ifdef CACHE_STATS_EN
        check({tag, "_stat_access"}, 64'(stat_access), 64'(m_access));
        check({tag, "_stat_hit"}, 64'(stat_hit), 64'(m_hit));
`endif
    endtask

    // Issues one CPU access (called #1 after a rising edge), queues its expected effects, holds until retired.
    task automatic do_access(input bit rd, input bit wr, input logic [15:0] addr, input logic [15:0] wd,
                             input int k, input logic [63:0] line);
        acc_exp_t    r;
        logic [15:0] base;
        bit          hit;
        int          waited;
        base = {addr[15:2], 2'b00};
        hit  = resident[addr[7:2]];
        if (wr) begin
            exp_mem.push_back('{1'b1, addr, wd});
            lat_q.push_back(k);
            rdata_q.push_back(64'h0);
            if (hit) exp_cw.push_back('{1'b1, addr, {wd, 48'h0}});
            r.stall = k + 2;
        end else begin
            m_access = m_access + 16'd1;
            if (hit) begin
                m_hit   = m_hit + 16'd1;
                r.stall = 0;
            end else begin
                exp_mem.push_back('{1'b0, base, 16'h0});
                lat_q.push_back(k);
                rdata_q.push_back(line);
                exp_cw.push_back('{1'b0, base, line});
                r.stall = k + 3;
            end
        end
        r.acc  = m_access;
        r.hits = m_hit;
        exp_acc.push_back(r);
        cpu_read  = rd;
        cpu_write = wr;
        cpu_addr  = addr;
        cpu_wdata = wd;
        waited    = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (cpu_stall && waited < 60);
        check("retire_in_budget", 64'(cpu_stall), 64'd0);
        @(posedge clk); #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
    endtask

    initial begin
        int          w;
        int          sel;
        int          idx;
        int          k;
        logic [15:0] a;
        logic [15:0] wd;
        logic [63:0] ld;

        reset     = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_idle("reset");
        @(posedge clk); #1;

        // Read hit, then read miss with a two-cycle ack.
        resident[6'h04] = 1'b1;
        do_access(1'b1, 1'b0, 16'h0010, 16'h0, 0, 64'h0);
        resident[6'h04] = 1'b0;
        do_access(1'b1, 1'b0, 16'h0013, 16'h0, 2, 64'hAAAA_BBBB_CCCC_DDDD);

        // Write hit, then write miss.
        resident[6'h08] = 1'b1;
        do_access(1'b0, 1'b1, 16'h0021, 16'h1234, 1, 64'h0);
        do_access(1'b0, 1'b1, 16'h0040, 16'h5678, 0, 64'h0);

        // Reset while waiting for a line; the ack arrives one cycle later.
        resident[6'h24] = 1'b0;
        exp_mem.push_back('{1'b0, 16'h0090, 16'h0});
        lat_q.push_back(1);
        rdata_q.push_back(64'h1111_2222_3333_4444);
        cpu_read = 1'b1;
        cpu_addr = 16'h0093;
        w = 0;
        while (mem_req !== 1'b1 && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("rd_req_reached", 64'(mem_req), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        cpu_read = 1'b0;
        m_access = '0;
        m_hit    = '0;
        repeat (3) begin
            @(negedge clk);
            check("post_reset_mem_req", 64'(mem_req), 64'd0);
            check("post_reset_no_fill", 64'(cache_writeC), 64'd0);
        end
        check_idle("mid_reset");
        @(posedge clk); #1;

        // Simultaneous read and write: only the write path runs.
        resident[6'h14] = 1'b0;
        do_access(1'b1, 1'b1, 16'h0050, 16'hBEEF, 2, 64'h0);

        // Randomized mix with occasional evictions.
        for (int t = 0; t < 80; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                idx = $urandom_range(0, 63);
                resident[idx] = 1'b0;
            end
            sel = $urandom_range(0, 9);
            a   = 16'($urandom_range(0, 255));
            wd  = 16'($urandom);
            k   = $urandom_range(0, 3);
            ld  = {$urandom, $urandom};
            do_access(sel <= 5 || sel == 9, sel >= 6, a, wd, k, ld);
        end

        repeat (4) @(negedge clk);
        check("mem_queue_drained", 64'(exp_mem.size()), 64'd0);
        check("cache_write_queue_drained", 64'(exp_cw.size()), 64'd0);
        check("access_queue_drained", 64'(exp_acc.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
